// File: rtl/csm_multi.sv
// csm_multi: multi-port register file with per-register locking.
//
// Each of NPORTS processor ports can read, write, lock (hold) or unlock (rel)
// one of MEMSIZE registers per cycle. All ports are evaluated on the same
// edge. Results (ack/err/rdata) are registered and appear one cycle later.
// A held register belongs to one port until that port releases it, or until
// LOCK_TIMEOUT cycles pass with no successful owner access.
//
// Ports:
//   clk, reset_n         clock (rising edge), async active-low reset
//   en/rw/hold/rel       per-port request valid, write(1)/read(0), lock, unlock
//   addr, wdata          per-port address / write data, port p at [p*W +: W]
//   rdata                per-port read data, held until the next good read
//   err                  per-port error code at [2p +: 2]
//                        00 ok, 01 in use, 10 dual write, 11 dual hold
//   ack                  per-port success pulse
//   locked               per-register lock-held flag (registered)
module csm_multi #(
    parameter int DATABITS     = 8,
    parameter int MEMSIZE      = 8,
    parameter int NPORTS       = 4,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NPORTS-1:0]                 en,
    input  logic [NPORTS-1:0]                 rw,
    input  logic [NPORTS-1:0]                 hold,
    input  logic [NPORTS-1:0]                 rel,
    input  logic [NPORTS*$clog2(MEMSIZE)-1:0] addr,
    input  logic [NPORTS*DATABITS-1:0]        wdata,
    output logic [NPORTS*DATABITS-1:0]        rdata,
    output logic [2*NPORTS-1:0]               err,
    output logic [NPORTS-1:0]                 ack,
    output logic [MEMSIZE-1:0]                locked
);
    localparam int AW = $clog2(MEMSIZE);
    localparam int OW = $clog2(NPORTS);
    // A zero timeout still needs a 1-bit counter to keep widths legal.
    localparam int CW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    localparam logic [1:0] E_OK    = 2'b00;
    localparam logic [1:0] E_INUSE = 2'b01;
    localparam logic [1:0] E_DUALW = 2'b10;
    localparam logic [1:0] E_DUALH = 2'b11;

    logic [NPORTS-1:0][AW-1:0]       a;
    logic [NPORTS-1:0][DATABITS-1:0] wd;
    assign a  = addr;
    assign wd = wdata;

    logic [MEMSIZE-1:0][DATABITS-1:0] mem_q, mem_d;
    logic [MEMSIZE-1:0]               lock_q, lock_d;
    logic [MEMSIZE-1:0][OW-1:0]       owner_q, owner_d;
    logic [MEMSIZE-1:0][CW-1:0]       idle_q, idle_d;
    logic [NPORTS-1:0][DATABITS-1:0]  rdata_q, rdata_d;
    logic [NPORTS-1:0][1:0]           err_q, err_d;
    logic [NPORTS-1:0]                ack_q, ack_d;

    logic [NPORTS-1:0] own;   // port p owns the lock on its target register
    logic [NPORTS-1:0] pass;  // port p clears the in-use checks
    logic [NPORTS-1:0] dw;    // write collision with another passing port
    logic [NPORTS-1:0] dh;    // hold collision with another passing port
    logic [NPORTS-1:0] ok;
    logic [NPORTS-1:0][1:0] code;

    // Ownership and in-use screening.
    always_comb begin
        own  = '0;
        pass = '0;
        for (int p = 0; p < NPORTS; p++) begin
            own[p]  = lock_q[a[p]] && (owner_q[a[p]] == OW'(p));
            pass[p] = en[p] && !(lock_q[a[p]] && !own[p]) && !(rel[p] && !own[p]);
        end
    end

    // Collisions only count among ports that survived the in-use checks.
    always_comb begin
        dw = '0;
        dh = '0;
        for (int p = 0; p < NPORTS; p++) begin
            for (int q = 0; q < NPORTS; q++) begin
                if (q != p && pass[p] && pass[q] && a[q] == a[p]) begin
                    if (rw[p] && rw[q])     dw[p] = 1'b1;
                    if (hold[p] && hold[q]) dh[p] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ok   = '0;
        code = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (!en[p])                            code[p] = E_OK;
            else if (!pass[p])                     code[p] = E_INUSE;
            else if (dw[p])                        code[p] = E_DUALW;
            else if (dh[p] && !lock_q[a[p]])       code[p] = E_DUALH;
            else begin
                code[p] = E_OK;
                ok[p]   = 1'b1;
            end
        end
    end

    // State update. Expiry is computed first so that a successful owner
    // access on the same edge overrides it.
    always_comb begin
        mem_d   = mem_q;
        lock_d  = lock_q;
        owner_d = owner_q;
        idle_d  = idle_q;
        rdata_d = rdata_q;
        ack_d   = ok;
        err_d   = code;

        for (int r = 0; r < MEMSIZE; r++) begin
            idle_d[r] = '0;
            if (lock_q[r] && LOCK_TIMEOUT != 0) begin
                if (idle_q[r] == CW'(LOCK_TIMEOUT)) lock_d[r] = 1'b0;
                else                                idle_d[r] = idle_q[r] + CW'(1);
            end
        end

        for (int p = 0; p < NPORTS; p++) begin
            if (ok[p]) begin
                // Reads see mem_q, so they observe the pre-write value.
                if (rw[p]) mem_d[a[p]]   = wd[p];
                else       rdata_d[p]    = mem_q[a[p]];
                if (hold[p]) begin
                    lock_d[a[p]]  = 1'b1;
                    owner_d[a[p]] = OW'(p);
                    idle_d[a[p]]  = '0;
                end else if (own[p]) begin
                    lock_d[a[p]]  = !rel[p];
                    idle_d[a[p]]  = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q   <= '0;
            lock_q  <= '0;
            owner_q <= '0;
            idle_q  <= '0;
            rdata_q <= '0;
            err_q   <= '0;
            ack_q   <= '0;
        end else begin
            mem_q   <= mem_d;
            lock_q  <= lock_d;
            owner_q <= owner_d;
            idle_q  <= idle_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
        end
    end

    assign rdata  = rdata_q;
    assign err    = err_q;
    assign ack    = ack_q;
    assign locked = lock_q;
endmodule

// File: tb/tb_csm_multi.sv
// Directed bench for csm_multi with default parameters (8-bit data,
// 8 registers, 4 ports, lock timeout 16).
module tb_csm_multi;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  en, rw, hold, rel;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  err;
    logic [3:0]  ack;
    logic [7:0]  locked;

    int n_checks = 0;
    int n_fail   = 0;

    csm_multi #(.DATABITS(8), .MEMSIZE(8), .NPORTS(4), .LOCK_TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .rw(rw), .hold(hold), .rel(rel),
        .addr(addr), .wdata(wdata), .rdata(rdata), .err(err), .ack(ack),
        .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic clear_in();
        en = '0; rw = '0; hold = '0; rel = '0; addr = '0; wdata = '0;
    endtask

    task automatic drive(input int p, input logic w, input logic h, input logic r,
                         input logic [2:0] ad, input logic [7:0] d);
        en[p] = 1'b1; rw[p] = w; hold[p] = h; rel[p] = r;
        addr[p*3 +: 3] = ad; wdata[p*8 +: 8] = d;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        clear_in();
        reset_n = 1'b0;
        step();
        n_checks++;
        if ({rdata, err, ack, locked} !== 52'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", {rdata, err, ack, locked});
        end
        @(negedge clk) reset_n = 1'b1;
        #1;
        n_checks++;
        if ({err, ack} !== 12'd0) begin
            n_fail++; $display("FAIL reset_release: got %h want 0", {err, ack});
        end
    endtask

    task automatic test_write_read();
        clear_in(); drive(0, 1, 0, 0, 3'd3, 8'hA5); step();
        n_checks++;
        if (ack !== 4'b0001 || err !== 8'h00) begin
            n_fail++; $display("FAIL wr_ack: got ack=%b err=%b want 0001/00000000", ack, err);
        end
        clear_in(); drive(1, 0, 0, 0, 3'd3, 8'h00); step();
        n_checks++;
        if (ack !== 4'b0010 || rdata[15:8] !== 8'hA5) begin
            n_fail++; $display("FAIL rd_after_wr: got ack=%b rdata1=%h want 0010/a5", ack, rdata[15:8]);
        end
        clear_in(); step();
        n_checks++;
        if (ack !== 4'b0000 || err !== 8'h00 || rdata[15:8] !== 8'hA5) begin
            n_fail++; $display("FAIL idle_hold: got ack=%b err=%b rdata1=%h want 0000/0/a5", ack, err, rdata[15:8]);
        end
    endtask

    task automatic test_dual_write();
        clear_in();
        drive(0, 1, 0, 0, 3'd5, 8'h11);
        drive(2, 1, 0, 0, 3'd5, 8'h22);
        drive(3, 1, 0, 0, 3'd6, 8'h66);
        step();
        n_checks++;
        if (ack !== 4'b1000 || err !== 8'b00_10_00_10) begin
            n_fail++; $display("FAIL dual_write: got ack=%b err=%b want 1000/00100010", ack, err);
        end
        // four simultaneous reads, three on the same address
        clear_in();
        drive(0, 0, 0, 0, 3'd5, 8'h00);
        drive(1, 0, 0, 0, 3'd5, 8'h00);
        drive(2, 0, 0, 0, 3'd5, 8'h00);
        drive(3, 0, 0, 0, 3'd6, 8'h00);
        step();
        n_checks++;
        if (ack !== 4'b1111 || err !== 8'h00) begin
            n_fail++; $display("FAIL multi_read: got ack=%b err=%b want 1111/0", ack, err);
        end
        n_checks++;
        if (rdata !== 32'h66_00_00_00) begin
            n_fail++; $display("FAIL dual_write_data: got rdata=%h want 66000000", rdata);
        end
    endtask

    task automatic test_lock();
        clear_in(); drive(1, 0, 1, 0, 3'd2, 8'h00); step();
        n_checks++;
        if (ack !== 4'b0010 || locked[2] !== 1'b1) begin
            n_fail++; $display("FAIL hold_grant: got ack=%b locked=%b want 0010/locked[2]=1", ack, locked);
        end
        clear_in();
        drive(0, 1, 0, 0, 3'd2, 8'h77);
        drive(3, 0, 0, 0, 3'd2, 8'h00);
        step();
        n_checks++;
        if (ack !== 4'b0000 || err !== 8'b01_00_00_01) begin
            n_fail++; $display("FAIL in_use: got ack=%b err=%b want 0000/01000001", ack, err);
        end
        clear_in(); drive(1, 0, 0, 1, 3'd2, 8'h00); step();
        n_checks++;
        if (ack !== 4'b0010 || locked[2] !== 1'b0 || rdata[15:8] !== 8'h00) begin
            n_fail++; $display("FAIL release: got ack=%b locked=%b rdata1=%h want 0010/locked[2]=0/00", ack, locked, rdata[15:8]);
        end
        // retry succeeds; a release of an unowned register is rejected
        clear_in();
        drive(0, 1, 0, 0, 3'd2, 8'h77);
        drive(2, 0, 0, 1, 3'd2, 8'h00);
        step();
        n_checks++;
        if (ack !== 4'b0001 || err !== 8'b00_01_00_00) begin
            n_fail++; $display("FAIL retry: got ack=%b err=%b want 0001/00010000", ack, err);
        end
    endtask

    task automatic test_dual_hold();
        clear_in();
        drive(0, 0, 1, 0, 3'd4, 8'h00);
        drive(1, 0, 1, 0, 3'd4, 8'h00);
        step();
        n_checks++;
        if (ack !== 4'b0000 || err !== 8'b00_00_11_11 || locked[4] !== 1'b0) begin
            n_fail++; $display("FAIL dual_hold: got ack=%b err=%b locked=%b want 0000/00001111/locked[4]=0", ack, err, locked);
        end
    endtask

    task automatic test_timeout();
        clear_in(); drive(2, 0, 1, 0, 3'd7, 8'h00); step();
        clear_in();
        repeat (16) step();
        n_checks++;
        if (locked[7] !== 1'b1) begin
            n_fail++; $display("FAIL timeout_early: got locked=%b want locked[7]=1", locked);
        end
        step();
        n_checks++;
        if (locked[7] !== 1'b0) begin
            n_fail++; $display("FAIL timeout_expire: got locked=%b want locked[7]=0", locked);
        end
        drive(0, 1, 0, 0, 3'd7, 8'h5A); step();
        n_checks++;
        if (ack !== 4'b0001 || err !== 8'h00) begin
            n_fail++; $display("FAIL post_expire_wr: got ack=%b err=%b want 0001/0", ack, err);
        end
    endtask

    task automatic test_owner_refresh();
        clear_in(); drive(2, 0, 1, 0, 3'd7, 8'h00); step();
        clear_in(); repeat (10) step();
        drive(2, 0, 0, 0, 3'd7, 8'h00); step();
        n_checks++;
        if (ack !== 4'b0100 || rdata[23:16] !== 8'h5A) begin
            n_fail++; $display("FAIL owner_read: got ack=%b rdata2=%h want 0100/5a", ack, rdata[23:16]);
        end
        clear_in(); repeat (16) step();
        n_checks++;
        if (locked[7] !== 1'b1) begin
            n_fail++; $display("FAIL refresh_hold: got locked=%b want locked[7]=1", locked);
        end
        step();
        n_checks++;
        if (locked[7] !== 1'b0) begin
            n_fail++; $display("FAIL refresh_expire: got locked=%b want locked[7]=0", locked);
        end
    endtask

    task automatic test_reset_mid();
        clear_in();
        drive(0, 0, 0, 0, 3'd1, 8'h00);
        drive(1, 1, 0, 0, 3'd1, 8'h3C);
        drive(3, 0, 1, 0, 3'd0, 8'h00);
        step();
        n_checks++;
        if (ack !== 4'b1011 || rdata[7:0] !== 8'h00 || locked[0] !== 1'b1) begin
            n_fail++; $display("FAIL rbw: got ack=%b rdata0=%h locked=%b want 1011/00/locked[0]=1", ack, rdata[7:0], locked);
        end
        // a fresh request is in flight when reset hits
        clear_in(); drive(0, 0, 0, 0, 3'd1, 8'h00);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({rdata, err, ack, locked} !== 52'd0) begin
            n_fail++; $display("FAIL async_reset: got %h want 0", {rdata, err, ack, locked});
        end
        clear_in();
        @(negedge clk) reset_n = 1'b1;
        drive(2, 0, 0, 0, 3'd1, 8'h00);
        step();
        n_checks++;
        if (ack !== 4'b0100 || rdata !== 32'd0 || locked !== 8'd0) begin
            n_fail++; $display("FAIL post_reset_read: got ack=%b rdata=%h locked=%b want 0100/0/0", ack, rdata, locked);
        end
    endtask

    initial begin
        clear_in();
        reset_n = 1'b0;
        test_reset();
        test_write_read();
        test_dual_write();
        test_lock();
        test_dual_hold();
        test_timeout();
        test_owner_refresh();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
